// File: rtl/mem_pkg.sv
// Shared encodings for the MEM-stage controller: access sizes, FSM states, funct codes.
package mem_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned LANES  = 4;

  localparam logic [1:0] DT_WORD = 2'b00;
  localparam logic [1:0] DT_HALF = 2'b01;
  localparam logic [1:0] DT_BYTE = 2'b10;

  localparam logic [5:0] FUNCT_JR = 6'h08;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    DONE   = 2'b10
  } state_t;

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// Data-memory req/ack bus between the MEM-stage controller and the data memory.
interface mem_stage_ctrl_if import mem_pkg::*; #(
  parameter int unsigned AW = 32
);

  logic              dmem_req;
  logic              dmem_we;
  logic [AW-1:0]     dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic [LANES-1:0]  dmem_be;
  logic              dmem_ack;
  logic [DATA_W-1:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output dmem_ack, dmem_rdata
  );

endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane steering: byte enables, store replication, load lane extract + sign extension.
module mem_lane_align import mem_pkg::*; (
  input  logic [1:0]        datatype,
  input  logic [1:0]        addr_lo,
  input  logic [DATA_W-1:0] store_data,
  input  logic [DATA_W-1:0] load_word,
  output logic [LANES-1:0]  be_c,
  output logic [DATA_W-1:0] wdata_c,
  output logic [DATA_W-1:0] load_ext_c
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane selection; datatype 11 falls through to word behaviour
  always_comb begin
    be_c       = '1;
    wdata_c    = store_data;
    load_ext_c = load_word;
    half_sel   = addr_lo[1] ? load_word[31:16] : load_word[15:0];
    case (addr_lo)
      2'd0:    byte_sel = load_word[7:0];
      2'd1:    byte_sel = load_word[15:8];
      2'd2:    byte_sel = load_word[23:16];
      default: byte_sel = load_word[31:24];
    endcase
    case (datatype)
      DT_BYTE: begin
        be_c       = LANES'(1) << addr_lo;
        wdata_c    = {4{store_data[7:0]}};
        load_ext_c = {{24{byte_sel[7]}}, byte_sel};
      end
      DT_HALF: begin
        be_c       = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_c    = {2{store_data[15:0]}};
        load_ext_c = {{16{half_sel[15]}}, half_sel};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: data-memory access FSM with req/ack, pipeline stall, branch/jump redirect.
// Optional feature: define MEM_MISALIGN_TRAP_EN to reject misaligned half/word accesses
// (MisalignErr pulse, no memory access) instead of silently aligning them.
module mem_stage_ctrl import mem_pkg::*; #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input  logic          Clk,
  input  logic          Clr_n,
  input  logic          MEM_MemRead,
  input  logic          MEM_MemWrite,
  input  logic [1:0]    MEM_Datatype,
  input  logic [AW-1:0] MEM_ALUResult,
  input  logic [DW-1:0] MEM_Data2,
  input  logic          MEM_Branch,
  input  logic          MEM_Zero,
  input  logic [AW-1:0] MEM_PCResult,
  input  logic          Jump_out,
  input  logic [5:0]    func_out,
  input  logic [AW-1:0] MEM_jumpImm,
  input  logic [AW-1:0] MEM_jumpRs,
  mem_stage_ctrl_if.master dmem,
  output logic [DW-1:0] MemReadData,
  output logic          Stall,
  output logic          Flush,
  output logic          PCSrc,
  output logic [AW-1:0] PCTarget,
  output logic          MisalignErr
);

  state_t         state;
  logic           is_access;
  logic           is_half;
  logic           is_word;
  logic           go;
  logic [AW-1:0]  addr_fix;
  logic [LANES-1:0] be_c;
  logic [DW-1:0]  wdata_c;
  logic [DW-1:0]  load_ext_c;

  // Access decode, address alignment and misalignment policy
  always_comb begin
    is_access = MEM_MemRead | MEM_MemWrite;
    is_half   = (MEM_Datatype == DT_HALF);
    is_word   = (MEM_Datatype != DT_HALF) && (MEM_Datatype != DT_BYTE);
    addr_fix  = MEM_ALUResult;
    if (is_half) addr_fix[0]   = 1'b0;
    if (is_word) addr_fix[1:0] = 2'b00;
`ifdef MEM_MISALIGN_TRAP_EN
    go          = is_access & ~((is_half & MEM_ALUResult[0]) | (is_word & (|MEM_ALUResult[1:0])));
    MisalignErr = (state == IDLE) & is_access & ~go;
`else
    go          = is_access;
    MisalignErr = 1'b0;
`endif
  end

  mem_lane_align u_lane (
    .datatype   (MEM_Datatype),
    .addr_lo    (addr_fix[1:0]),
    .store_data (MEM_Data2),
    .load_word  (dmem.dmem_rdata),
    .be_c       (be_c),
    .wdata_c    (wdata_c),
    .load_ext_c (load_ext_c)
  );

  // Access FSM with registered memory-bus outputs and load result
  always_ff @(posedge Clk or negedge Clr_n) begin
    if (!Clr_n) begin
      state           <= IDLE;
      dmem.dmem_req   <= 1'b0;
      dmem.dmem_we    <= 1'b0;
      dmem.dmem_addr  <= '0;
      dmem.dmem_wdata <= '0;
      dmem.dmem_be    <= '0;
      MemReadData     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (go) begin
            state           <= ACCESS;
            dmem.dmem_req   <= 1'b1;
            dmem.dmem_we    <= MEM_MemWrite;
            dmem.dmem_addr  <= {addr_fix[AW-1:2], 2'b00};
            dmem.dmem_wdata <= wdata_c;
            dmem.dmem_be    <= be_c;
          end
        end
        ACCESS: begin
          if (dmem.dmem_ack) begin
            state         <= DONE;
            dmem.dmem_req <= 1'b0;
            dmem.dmem_we  <= 1'b0;
            if (!dmem.dmem_we) MemReadData <= load_ext_c;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Pipeline hold and redirect resolution
  always_comb begin
    Stall    = ((state == IDLE) & go) | (state == ACCESS);
    PCSrc    = (MEM_Branch & MEM_Zero) | Jump_out;
    PCTarget = Jump_out ? ((func_out == FUNCT_JR) ? MEM_jumpRs : MEM_jumpImm) : MEM_PCResult;
    Flush    = PCSrc & ~Stall;
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl (directed vectors + per-cycle reference model).
module tb_mem_stage_ctrl;

  logic        Clk, Clr_n;
  logic        MEM_MemRead, MEM_MemWrite;
  logic [1:0]  MEM_Datatype;
  logic [31:0] MEM_ALUResult, MEM_Data2, MEM_PCResult, MEM_jumpImm, MEM_jumpRs;
  logic        MEM_Branch, MEM_Zero, Jump_out;
  logic [5:0]  func_out;
  logic [31:0] MemReadData, PCTarget;
  logic        Stall, Flush, PCSrc, MisalignErr;

  mem_stage_ctrl_if #(.AW(32)) dmem_bus ();

  mem_stage_ctrl dut (
    .Clk(Clk), .Clr_n(Clr_n),
    .MEM_MemRead(MEM_MemRead), .MEM_MemWrite(MEM_MemWrite), .MEM_Datatype(MEM_Datatype),
    .MEM_ALUResult(MEM_ALUResult), .MEM_Data2(MEM_Data2),
    .MEM_Branch(MEM_Branch), .MEM_Zero(MEM_Zero), .MEM_PCResult(MEM_PCResult),
    .Jump_out(Jump_out), .func_out(func_out), .MEM_jumpImm(MEM_jumpImm), .MEM_jumpRs(MEM_jumpRs),
    .dmem(dmem_bus),
    .MemReadData(MemReadData), .Stall(Stall), .Flush(Flush), .PCSrc(PCSrc),
    .PCTarget(PCTarget), .MisalignErr(MisalignErr)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_err = 0;
  int n_checks = 0;

  // Model expectations, updated by the stimulus tasks
  logic        chk_en = 1'b0;
  logic        exp_stall = 1'b0, exp_req = 1'b0, exp_we = 1'b0, exp_merr = 1'b0;
  logic [31:0] exp_addr = '0, exp_wdata = '0, exp_mrd = '0;
  logic [3:0]  exp_be = '0;

  // Values captured by do_mem for literal checks
  int          stall_cnt;
  logic        flush_first, flush_last, cap_we, merr_seen;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_be;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int unsigned m_size(input logic [1:0] dt);
    case (dt)
      2'b10:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic [31:0] m_align(input logic [31:0] a, input int unsigned sz);
    return a & ~32'(sz - 1);
  endfunction

  function automatic logic [3:0] m_be(input logic [31:0] al, input int unsigned sz);
    return 4'(32'((1 << sz) - 1) << (al % 4));
  endfunction

  function automatic logic [31:0] m_wdata(input logic [31:0] d, input int unsigned sz);
    if (sz == 1) return {24'b0, d[7:0]} * 32'h0101_0101;
    if (sz == 2) return {16'b0, d[15:0]} * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] w, input logic [31:0] al, input int unsigned sz);
    logic [31:0] v;
    v = w >> (8 * (al % 4));
    if (sz == 1) return {{24{v[7]}}, v[7:0]};
    if (sz == 2) return {{16{v[15]}}, v[15:0]};
    return v;
  endfunction

  // Per-cycle comparison of every output against the model
  always @(negedge Clk) begin
    logic        pcs;
    logic [31:0] tgt;
    if (chk_en) begin
      pcs = (MEM_Branch && MEM_Zero) || Jump_out;
      tgt = Jump_out ? ((func_out == 6'h08) ? MEM_jumpRs : MEM_jumpImm) : MEM_PCResult;
      chk("PCSrc", PCSrc, pcs);
      chk("PCTarget", PCTarget, tgt);
      chk("Stall", Stall, exp_stall);
      chk("Flush", Flush, pcs & ~exp_stall);
      chk("dmem_req", dmem_bus.dmem_req, exp_req);
      if (exp_req) begin
        chk("dmem_we", dmem_bus.dmem_we, exp_we);
        chk("dmem_addr", dmem_bus.dmem_addr, exp_addr);
        chk("dmem_be", dmem_bus.dmem_be, exp_be);
        chk("dmem_wdata", dmem_bus.dmem_wdata, exp_wdata);
      end
      chk("MemReadData", MemReadData, exp_mrd);
      chk("MisalignErr", MisalignErr, exp_merr);
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_nop();
    MEM_MemRead = 1'b0;
    MEM_MemWrite = 1'b0;
    MEM_Datatype = 2'b00;
    MEM_ALUResult = '0;
    MEM_Data2 = '0;
    exp_stall = 1'b0;
    exp_req = 1'b0;
  endtask

  task automatic set_redirect(input logic br, input logic z, input logic [31:0] pcr,
                              input logic j, input logic [5:0] f,
                              input logic [31:0] imm, input logic [31:0] rs);
    MEM_Branch = br; MEM_Zero = z; MEM_PCResult = pcr;
    Jump_out = j; func_out = f; MEM_jumpImm = imm; MEM_jumpRs = rs;
  endtask

  task automatic idle(input int n);
    set_nop();
    for (int i = 0; i < n; i++) step();
  endtask

  // One memory instruction in MEM: IDLE cycle, ACCESS with `waits` ack-less cycles, DONE
  task automatic do_mem(input logic rd, input logic wr, input logic [1:0] dt,
                        input logic [31:0] a, input logic [31:0] d2,
                        input logic [31:0] rword, input int waits);
    int unsigned sz;
    logic [31:0] al;
    sz = m_size(dt);
    al = m_align(a, sz);
    stall_cnt = 0;
    merr_seen = 1'b0;
    MEM_MemRead = rd; MEM_MemWrite = wr; MEM_Datatype = dt;
    MEM_ALUResult = a; MEM_Data2 = d2;
`ifdef MEM_MISALIGN_TRAP_EN
    if ((a % sz) != 0) begin
      exp_merr = 1'b1; exp_stall = 1'b0; exp_req = 1'b0;
      @(negedge Clk);
      merr_seen = MisalignErr;
      stall_cnt += int'(Stall);
      step();
      exp_merr = 1'b0;
      set_nop();
      return;
    end
`endif
    exp_stall = 1'b1; exp_req = 1'b0;
    @(negedge Clk);
    stall_cnt += int'(Stall);
    flush_first = Flush;
    step();
    exp_req = 1'b1; exp_we = wr; exp_addr = al & ~32'd3;
    exp_be = m_be(al, sz); exp_wdata = m_wdata(d2, sz);
    for (int i = 0; i <= waits; i++) begin
      dmem_bus.dmem_ack = (i == waits);
      dmem_bus.dmem_rdata = (i == waits) ? rword : ~rword;
      @(negedge Clk);
      stall_cnt += int'(Stall);
      if (i == 0) begin
        cap_addr = dmem_bus.dmem_addr; cap_be = dmem_bus.dmem_be;
        cap_wdata = dmem_bus.dmem_wdata; cap_we = dmem_bus.dmem_we;
      end
      step();
    end
    dmem_bus.dmem_ack = 1'b0;
    exp_req = 1'b0; exp_stall = 1'b0;
    if (!wr) exp_mrd = m_load(rword, al, sz);
    @(negedge Clk);
    stall_cnt += int'(Stall);
    flush_last = Flush;
    step();
    set_nop();
  endtask

  initial begin
    Clr_n = 1'b0;
    dmem_bus.dmem_ack = 1'b0;
    dmem_bus.dmem_rdata = '0;
    set_nop();
    set_redirect(1'b0, 1'b0, '0, 1'b0, 6'd0, '0, '0);
    step();
    chk("rst_req", dmem_bus.dmem_req, 32'd0);
    chk("rst_we", dmem_bus.dmem_we, 32'd0);
    chk("rst_addr", dmem_bus.dmem_addr, 32'd0);
    chk("rst_wdata", dmem_bus.dmem_wdata, 32'd0);
    chk("rst_be", dmem_bus.dmem_be, 32'd0);
    chk("rst_mrd", MemReadData, 32'd0);
    chk("rst_merr", MisalignErr, 32'd0);
    chk("rst_stall", Stall, 32'd0);
    Clr_n = 1'b1;
    step();
    chk_en = 1'b1;
    idle(2);

    // Redirects with no memory access
    set_redirect(1'b1, 1'b1, 32'h40, 1'b0, 6'd0, '0, '0);
    @(negedge Clk);
    chk("br_pcsrc", PCSrc, 32'd1);
    chk("br_target", PCTarget, 32'h40);
    chk("br_flush", Flush, 32'd1);
    step();
    set_redirect(1'b1, 1'b0, 32'h40, 1'b0, 6'd0, '0, '0);
    @(negedge Clk);
    chk("br_nt_pcsrc", PCSrc, 32'd0);
    step();
    set_redirect(1'b0, 1'b0, '0, 1'b1, 6'h08, 32'h200, 32'h100);
    @(negedge Clk);
    chk("jr_target", PCTarget, 32'h100);
    step();
    set_redirect(1'b0, 1'b0, '0, 1'b1, 6'h00, 32'h200, 32'h100);
    @(negedge Clk);
    chk("j_target", PCTarget, 32'h200);
    step();
    set_redirect(1'b0, 1'b0, '0, 1'b0, 6'd0, '0, '0);
    idle(1);

    do_mem(1'b0, 1'b1, 2'b10, 32'h1003, 32'h0000_00A5, 32'h0, 0);
    chk("sb_addr", cap_addr, 32'h1000);
    chk("sb_be", cap_be, 32'h8);
    chk("sb_wdata", cap_wdata, 32'hA5A5_A5A5);
    chk("sb_we", cap_we, 32'd1);
    chk("sb_stall_cycles", stall_cnt, 32'd2);

    do_mem(1'b1, 1'b0, 2'b01, 32'h2002, 32'h0, 32'h8001_1234, 3);
    chk("lh_mrd", MemReadData, 32'hFFFF_8001);
    chk("lh_stall_cycles", stall_cnt, 32'd5);

    do_mem(1'b0, 1'b1, 2'b01, 32'h0006, 32'h1234_BEEF, 32'h0, 1);
    chk("sh_be", cap_be, 32'hC);
    chk("sh_wdata", cap_wdata, 32'hBEEF_BEEF);

    do_mem(1'b1, 1'b0, 2'b10, 32'h0011, 32'h0, 32'h1234_8056, 2);
    chk("lb_mrd", MemReadData, 32'hFFFF_FF80);

    do_mem(1'b1, 1'b0, 2'b00, 32'h0020, 32'h0, 32'hDEAD_BEEF, 0);
    chk("lw_mrd", MemReadData, 32'hDEAD_BEEF);

    do_mem(1'b1, 1'b0, 2'b01, 32'h2000, 32'h0, 32'h8001_1234, 0);
    chk("lh_pos_mrd", MemReadData, 32'h0000_1234);

    do_mem(1'b1, 1'b1, 2'b11, 32'h0044, 32'hCAFE_F00D, 32'h5555_5555, 0);
    chk("rw_we", cap_we, 32'd1);
    chk("rw_wdata", cap_wdata, 32'hCAFE_F00D);
    chk("rw_mrd_hold", MemReadData, 32'h0000_1234);

    // Load with a taken branch: flush waits for DONE
    set_redirect(1'b1, 1'b1, 32'h80, 1'b0, 6'd0, '0, '0);
    do_mem(1'b1, 1'b0, 2'b10, 32'h0008, 32'h0, 32'h0000_007F, 1);
    chk("ldbr_flush_idle", flush_first, 32'd0);
    chk("ldbr_flush_done", flush_last, 32'd1);
    chk("ldbr_mrd", MemReadData, 32'h0000_007F);
    set_redirect(1'b0, 1'b0, '0, 1'b0, 6'd0, '0, '0);

    // Stray ack while idle must be ignored
    dmem_bus.dmem_ack = 1'b1;
    dmem_bus.dmem_rdata = 32'hFFFF_FFFF;
    idle(2);
    dmem_bus.dmem_ack = 1'b0;
    chk("stray_ack_mrd", MemReadData, 32'h0000_007F);

    do_mem(1'b1, 1'b0, 2'b00, 32'h3002, 32'h0, 32'h1122_3344, 0);
`ifdef MEM_MISALIGN_TRAP_EN
    chk("mis_merr", merr_seen, 32'd1);
    chk("mis_stall_cycles", stall_cnt, 32'd0);
    chk("mis_mrd_hold", MemReadData, 32'h0000_007F);
`else
    chk("mis_addr", cap_addr, 32'h3000);
    chk("mis_be", cap_be, 32'hF);
    chk("mis_mrd", MemReadData, 32'h1122_3344);
`endif
    idle(1);

    // Reset asserted while an access is outstanding
    chk_en = 1'b0;
    MEM_MemRead = 1'b1; MEM_Datatype = 2'b00; MEM_ALUResult = 32'h40;
    step();
    chk("acc_req", dmem_bus.dmem_req, 32'd1);
    #2;
    Clr_n = 1'b0;
    #1;
    chk("rst_mid_req", dmem_bus.dmem_req, 32'd0);
    set_nop();
    #1;
    chk("rst_mid_stall", Stall, 32'd0);
    step();
    Clr_n = 1'b1;
    @(negedge Clk);
    chk("post_rst_stall", Stall, 32'd0);
    chk("post_rst_req", dmem_bus.dmem_req, 32'd0);
    chk("post_rst_mrd", MemReadData, 32'd0);
    exp_mrd = '0;
    step();
    chk_en = 1'b1;
    idle(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_stage_ctrl.md
# mem_stage_ctrl

MEM-stage controller that consumes the EX/MEM pipeline register outputs and performs the data-memory access with a req/ack handshake. It generates byte-lane enables and store alignment, extracts and sign-extends load data, and resolves branch and jump redirection. While an access is outstanding it holds the pipeline with `Stall`; on a taken redirect it produces `Flush` for the upstream pipeline registers.

## Interface
Parameters:
- `AW`, 32, data address width.
- `DW`, 32, data width; fixed at 32, byte lanes = 4.

Ports:
- `Clk`  in  1  pipeline clock.
- `Clr_n`  in  1  asynchronous active-low reset.
- `MEM_MemRead`  in  1  load in MEM stage.
- `MEM_MemWrite`  in  1  store in MEM stage.
- `MEM_Datatype`  in  2  access size: 00 word, 01 half, 10 byte, 11 treated as word.
- `MEM_ALUResult`  in  32  effective byte address.
- `MEM_Data2`  in  32  store data, right-justified.
- `MEM_Branch`, `MEM_Zero`  in  1 each  branch instruction / ALU zero.
- `MEM_PCResult`  in  32  branch target.
- `Jump_out`  in  1  jump instruction.
- `func_out`  in  6  funct field; 6'h08 selects jr.
- `MEM_jumpImm`, `MEM_jumpRs`  in  32 each  immediate / register jump targets.
- `dmem_req`  out  1  memory request, held until ack.
- `dmem_we`  out  1  write request.
- `dmem_addr`  out  32  word-aligned address (low 2 bits zero).
- `dmem_wdata`  out  32  lane-replicated store data.
- `dmem_be`  out  4  byte enables, little-endian.
- `dmem_ack`  in  1  request accepted/completed; `dmem_rdata` valid the same cycle.
- `dmem_rdata`  in  32  read word.
- `MemReadData`  out  32  registered, extended load result.
- `Stall`  out  1  drives EX/MEM `Ld` low and freezes upstream stages.
- `Flush`  out  1  drives IF/ID and ID/EX `Clr`.
- `PCSrc`  out  1  select redirect target.
- `PCTarget`  out  32  redirect target.
- `MisalignErr`  out  1  misaligned access flag (see Configuration).

## Operation
- FSM states `IDLE`, `ACCESS`, `DONE`.
- `IDLE`: if (`MemRead` | `MemWrite`) and the access is not suppressed, go to `ACCESS`. `Stall` is 1 combinationally in this cycle.
- `ACCESS`: `dmem_req`=1 and `Stall`=1. Address, data, `be` and `we` are registered at entry and stay stable. On `dmem_ack`, capture the extended `dmem_rdata` into `MemReadData` (loads only) and go to `DONE`.
- `DONE`: `Stall`=0 for exactly one cycle so EX/MEM advances, then unconditionally return to `IDLE`. There is no re-trigger on the same instruction.
- `MemRead` and `MemWrite` both set: treated as a write.
- Byte lanes:
  - byte: `be`=1<<addr[1:0], `wdata`={4{Data2[7:0]}}.
  - half: `be`=addr[1]?1100:0011, `wdata`={2{Data2[15:0]}}.
  - word: `be`=1111.
- Load extract: select the lane by addr[1:0]/addr[1], then sign-extend to 32 bits.
- Redirect: `PCSrc` = (`MEM_Branch` & `MEM_Zero`) | `Jump_out`.
  - `PCTarget` = `Jump_out` ? (`func_out`==6'h08 ? `MEM_jumpRs` : `MEM_jumpImm`) : `MEM_PCResult`.
- `Flush` = `PCSrc` & ~`Stall`.

## Timing
- Reset values: state `IDLE`, `dmem_req`/`dmem_we`=0, `dmem_addr`/`dmem_wdata`/`MemReadData`=0, `dmem_be`=0, `MisalignErr`=0.
- `Stall`, `Flush` and `PCSrc` are combinational.
- Minimum MEM occupancy for an access (ack in the first `ACCESS` cycle) is 3 cycles; each wait cycle without ack adds 1.
- Non-memory instructions pass in 1 cycle with `Stall`=0.
- `MemReadData` updates on the ack edge and holds until the next load ack.
- Reset asserted mid-`ACCESS`: `dmem_req` drops immediately (asynchronously) and the access is abandoned. The memory must tolerate a dropped request.
- Ack outside `ACCESS`: ignored.

## Configuration
- `MEM_MISALIGN_TRAP_EN` defined:
  - A half access with addr[0]=1, or a word access with addr[1:0]≠0, never enters `ACCESS`.
  - `MisalignErr` pulses high for that one `IDLE` cycle and `Stall` stays 0.
- Undefined:
  - Offending low address bits are forced to zero (half clears addr[0]; word clears addr[1:0]) and the access proceeds.
  - `MisalignErr` is tied 0.

## Structure
- Shared package `mem_pkg`:
  - datatype encodings `DT_WORD`/`DT_HALF`/`DT_BYTE`
  - state enum
  - `FUNCT_JR`=6'h08
- One combinational sub-module `mem_lane_align`: byte-enable generation, store replication, and load extract/sign-extend. The FSM and redirect logic stay in the top level.

## Test plan
- Byte store: `MemWrite`=1, `Datatype`=10, addr 0x1003, `Data2`=0x000000A5, ack in first `ACCESS` cycle → `dmem_addr`=0x1000, `be`=1000, `wdata`=0xA5A5A5A5, `Stall` high 2 cycles then low.
- Half load: addr 0x2002, `rdata`=0x8001_1234, ack after 3 waits → `MemReadData`=0xFFFF8001, `Stall` high 5 cycles.
- Branch: `Branch`=1, `Zero`=1, `PCResult`=0x40 → `PCSrc`=1, `PCTarget`=0x40, `Flush`=1 same cycle; with a concurrent load, `Flush` is delayed to `DONE`.
- jr: `Jump_out`=1, `func_out`=6'h08, `jumpRs`=0x100, `jumpImm`=0x200 → `PCTarget`=0x100; with `func_out`=0 → 0x200.
- Misaligned word addr 0x3002: with the macro → `MisalignErr` 1 cycle, no `dmem_req`; without it → `dmem_addr`=0x3000, `be`=1111.
- `Clr_n` low during `ACCESS` → `dmem_req`=0 immediately, state `IDLE`, `Stall`=0 after release.
